// File: rtl/serial_capture_mc.sv
// Multi-channel UART receive monitor: per-channel 8N1 deserialisers whose bytes
// are tagged, arbitrated round-robin and merged into one FWFT output FIFO.
module serial_capture_mc #(
    parameter int NUM_CH     = 2,
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] rx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [CH_W-1:0]   out_chan,
    output logic              out_ferr,
    output logic [NUM_CH-1:0] overflow,
    input  logic              clear_ovf,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    logic [1:0]        rst_sync_r;
    logic              rst_n_s;
    logic              gnt_valid_s;
    logic [CH_W-1:0]   gnt_idx_s;
    logic [CH_W:0]     scan_idx_s;
    logic [CH_W-1:0]   rr_ptr_r;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [NUM_CH-1:0] overflow_r;

    wire  [NUM_CH-1:0] hold_full_s;
    wire  [NUM_CH-1:0] hold_ferr_s;
    wire  [NUM_CH-1:0] ovf_set_s;
    wire  [7:0]        hold_data_s [NUM_CH];

    logic [7:0]            mem_data_r [FIFO_DEPTH];
    logic [CH_W-1:0]       mem_chan_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_ferr_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LVL_W-1:0]      level_r;

    // Reset synchroniser: assert immediately, release two edges later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]       sync_r;
        logic             rx_s;
        rx_state_e        state_r;
        rx_state_e        state_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_s;
        logic [2:0]       bit_r;
        logic [2:0]       bit_s;
        logic [7:0]       shift_r;
        logic [7:0]       shift_s;
        logic             emit_s;
        logic             ferr_s;
        logic             drain_s;
        logic             hold_full_r;
        logic             hold_ferr_r;
        logic [7:0]       hold_data_r;

        assign rx_s    = sync_r[1];
        assign drain_s = push_s && (gnt_idx_s == CH_W'(g));

        // Two-flop synchroniser for the asynchronous rx line.
        always_ff @(posedge clk or negedge rst_n_s) begin
            if (!rst_n_s) begin
                sync_r <= 2'b11;
            end else begin
                sync_r <= {sync_r[0], rx[g]};
            end
        end

        // Receiver state register.
        always_ff @(posedge clk or negedge rst_n_s) begin
            if (!rst_n_s) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
                bit_r   <= 3'd0;
                shift_r <= 8'h00;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                bit_r   <= bit_s;
                shift_r <= shift_s;
            end
        end

        // Receiver next-state: mid-bit sampling off a per-bit down-counter.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            bit_s   = bit_r;
            shift_s = shift_r;
            emit_s  = 1'b0;
            ferr_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_s = ST_START;
                        cnt_s   = HALF_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_r == '0) begin
                        if (rx_s) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_DATA;
                            cnt_s   = FULL_LOAD;
                            bit_s   = 3'd0;
                        end
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == '0) begin
                        shift_s = {rx_s, shift_r[7:1]};
                        cnt_s   = FULL_LOAD;
                        if (bit_r == 3'd7) begin
                            state_s = ST_STOP;
                        end else begin
                            bit_s = bit_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == '0) begin
                        emit_s  = 1'b1;
                        ferr_s  = ~rx_s;
                        state_s = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BREAK;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // Holding register; a byte arriving while it is occupied is dropped.
        always_ff @(posedge clk or negedge rst_n_s) begin
            if (!rst_n_s) begin
                hold_full_r <= 1'b0;
                hold_ferr_r <= 1'b0;
                hold_data_r <= 8'h00;
            end else if (emit_s && (!hold_full_r || drain_s)) begin
                hold_full_r <= 1'b1;
                hold_ferr_r <= ferr_s;
                hold_data_r <= shift_r;
            end else if (drain_s) begin
                hold_full_r <= 1'b0;
            end
        end

        assign hold_full_s[g] = hold_full_r;
        assign hold_ferr_s[g] = hold_ferr_r;
        assign hold_data_s[g] = hold_data_r;
        assign ovf_set_s[g]   = emit_s && hold_full_r && !drain_s;
    end

    // Round-robin pick: scan downward so the channel nearest the pointer wins.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        scan_idx_s  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scan_idx_s = {1'b0, rr_ptr_r} + (CH_W + 1)'(i);
            if (scan_idx_s >= (CH_W + 1)'(NUM_CH)) begin
                scan_idx_s = scan_idx_s - (CH_W + 1)'(NUM_CH);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (hold_full_s[scan_idx_s[CH_W-1:0]]) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = scan_idx_s[CH_W-1:0];
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
    end

    assign empty_s = (level_r == '0);
    assign full_s  = (level_r == LVL_W'(FIFO_DEPTH));
    assign pop_s   = !empty_s && out_ready;
    assign push_s  = gnt_valid_s && (!full_s || pop_s);

    // Arbiter pointer advances past the channel just granted.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rr_ptr_r <= '0;
        end else if (push_s) begin
            rr_ptr_r <= (gnt_idx_s == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_s + CH_W'(1);
        end
    end

    // Sticky overflow flags; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            overflow_r <= '0;
        end else begin
            overflow_r <= (overflow_r & ~{NUM_CH{clear_ovf}}) | ovf_set_s;
        end
    end

    // FIFO storage, cleared so the head fields read zero after reset.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= 8'h00;
                mem_chan_r[i] <= '0;
            end
            mem_ferr_r <= '0;
        end else if (push_s) begin
            mem_data_r[wr_ptr_r] <= hold_data_s[gnt_idx_s];
            mem_chan_r[wr_ptr_r] <= gnt_idx_s;
            mem_ferr_r[wr_ptr_r] <= hold_ferr_s[gnt_idx_s];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign out_valid  = ~empty_s;
    assign out_data   = mem_data_r[rd_ptr_r];
    assign out_chan   = mem_chan_r[rd_ptr_r];
    assign out_ferr   = mem_ferr_r[rd_ptr_r];
    assign overflow   = overflow_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_serial_capture_mc.sv
// Directed bench for serial_capture_mc: frames are driven on rx, expected
// entries are queued at stimulus time and compared as the FIFO head is taken.
module tb_serial_capture_mc;

    localparam int NUM_CH     = 2;
    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int CH_W       = 1;
    localparam int LVL_W      = 5;
    localparam int LATENCY    = CLK_DIV / 2 + 9 * CLK_DIV + 4;

    typedef struct packed {
        logic [7:0]      data;
        logic [CH_W-1:0] chan;
        logic            ferr;
    } entry_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NUM_CH-1:0] rx;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [CH_W-1:0]   out_chan;
    logic              out_ferr;
    logic [NUM_CH-1:0] overflow;
    logic              clear_ovf;
    logic [LVL_W-1:0]  fifo_level;

    entry_t sb[$];
    int     n_checks   = 0;
    int     n_errors   = 0;
    int     cyc        = 0;
    int     valid_cnt  = 0;
    int     rise_cyc   = 0;
    int     t_start    = 0;
    logic   prev_valid = 1'b0;

    serial_capture_mc #(
        .NUM_CH    (NUM_CH),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ferr  (out_ferr),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [CH_W-1:0] c, input logic f);
        entry_t e;
        e.data = d;
        e.chan = c;
        e.ferr = f;
        sb.push_back(e);
    endtask

    // Head monitor: sampled mid-low-phase, so a seen handshake completes at the next rising edge.
    always @(negedge clk) begin
        entry_t e;
        #2;
        if (out_valid === 1'b1) valid_cnt++;
        if (out_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = out_valid;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_chan", out_chan, e.chan);
                check("out_ferr", out_ferr, e.ferr);
            end
        end
    end

    task automatic send_frame(input logic [NUM_CH-1:0] mask, input logic [7:0] b0,
                              input logic [7:0] b1, input logic stop_bit);
        @(negedge clk);
        rx = rx & ~mask;
        t_start = cyc;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask[c]) rx[c] = (c == 0) ? b0[i] : b1[i];
            end
            repeat (CLK_DIV) @(negedge clk);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c]) rx[c] = stop_bit;
        end
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || out_valid !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_left", sb.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data, 0);
        check({tag, "_chan"},  out_chan, 0);
        check({tag, "_ferr"},  out_ferr, 0);
        check({tag, "_ovf"},   overflow, 0);
        check({tag, "_level"}, fifo_level, 0);
    endtask

    initial begin
        int v0;
        int t1;
        logic [7:0] partial;
        resetn    = 1'b0;
        rx        = '1;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte, latency and one-cycle valid
        out_ready = 1'b1;
        v0 = valid_cnt;
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(2'b01, 8'hA5, 8'h00, 1'b1);
        t1 = t_start;
        wait_drain(200);
        check("a5_latency", rise_cyc - t1, LATENCY);
        check("a5_valid_cycles", valid_cnt - v0, 1);

        // Start-bit glitch on rx[1] is rejected, receiver still usable
        v0 = valid_cnt;
        @(negedge clk);
        rx[1] = 1'b0;
        repeat (CLK_DIV / 4) @(negedge clk);
        rx[1] = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_ovf", overflow, 0);
        push_exp(8'h5A, 1'b1, 1'b0);
        send_frame(2'b10, 8'h00, 8'h5A, 1'b1);
        wait_drain(200);

        // Framing error followed by a held-low line yields a single entry
        v0 = valid_cnt;
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(2'b01, 8'h3C, 8'h00, 1'b0);
        repeat (30 * CLK_DIV) @(negedge clk);
        check("break_single", valid_cnt - v0, 1);
        rx[0] = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(2'b01, 8'h55, 8'h00, 1'b1);
        wait_drain(200);

        // Simultaneous bytes on both channels drain in round-robin order
        pulse_reset();
        out_ready = 1'b0;
        push_exp(8'h11, 1'b0, 1'b0);
        push_exp(8'h22, 1'b1, 1'b0);
        send_frame(2'b11, 8'h11, 8'h22, 1'b1);
        repeat (8) @(negedge clk);
        check("dual_level", fifo_level, 2);
        check("dual_ovf", overflow, 0);
        out_ready = 1'b1;
        wait_drain(100);

        // Fill FIFO and holding register, drop the 18th byte
        out_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k < 17) push_exp(8'(k), 1'b0, 1'b0);
            send_frame(2'b01, 8'(k), 8'h00, 1'b1);
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("full_level", fifo_level, 16);
        check("full_ovf", overflow, 2'b01);
        out_ready = 1'b1;
        wait_drain(300);
        check("ovf_sticky", overflow, 2'b01);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);

        // Reset during bit 4 abandons the partial byte
        v0 = valid_cnt;
        partial = 8'hF0;
        @(negedge clk);
        rx[1] = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx[1] = partial[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx[1] = partial[4];
        repeat (CLK_DIV / 2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        rx = '1;
        resetn = 1'b1;
        repeat (12 * CLK_DIV) @(negedge clk);
        check("midrst_no_byte", valid_cnt - v0, 0);
        check("midrst_level", fifo_level, 0);
        push_exp(8'h7E, 1'b1, 1'b0);
        send_frame(2'b10, 8'h00, 8'h7E, 1'b1);
        wait_drain(200);

        check("sb_final_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
